// File: rtl/calc_e_iter.sv
// Iterative LABS energy engine: E = sum over lags k of C_k^2 for one sequence,
// LAGS_PER_CYCLE lags per cycle, with tag pass-through and a minimum-energy tracker.
module calc_e_iter #(
    parameter int SEQ_WIDTH      = 30,
    parameter int LAGS_PER_CYCLE = 4,
    parameter int E_WIDTH        = 20,
    parameter int TAG_WIDTH      = 8,
    localparam int LEN_W         = $clog2(SEQ_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SEQ_WIDTH-1:0] i_seq,
    input  logic [LEN_W-1:0]     i_len,
    input  logic [TAG_WIDTH-1:0] i_tag,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [E_WIDTH-1:0]   o_e,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic                 o_valid,
    input  logic                 i_ready,
    input  logic                 i_clr_best,
    output logic [E_WIDTH-1:0]   o_best_e,
    output logic [TAG_WIDTH-1:0] o_best_tag
);
    // One extra bit on lag indices so k + LAGS_PER_CYCLE - 1 never wraps.
    localparam int KW    = LEN_W + 1;
    localparam int CW    = $clog2(SEQ_WIDTH) + 1;
    localparam int SQW   = 2 * CW;
    localparam int ACC_W = 3 * LEN_W;
    localparam int CMP_W = ((ACC_W > E_WIDTH) ? ACC_W : E_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_reg, state_next;
    logic [SEQ_WIDTH-1:0] seq_reg, seq_next;
    logic [LEN_W-1:0]     lc_reg, lc_next;
    logic [TAG_WIDTH-1:0] tag_reg, tag_next;
    logic [KW-1:0]        k_reg, k_next;
    logic [ACC_W-1:0]     acc_reg, acc_next;
    logic                 ready_reg, ready_next;
    logic                 valid_reg, valid_next;
    logic [E_WIDTH-1:0]   e_reg, e_next;
    logic [TAG_WIDTH-1:0] out_tag_reg, out_tag_next;
    logic [E_WIDTH-1:0]   best_e_reg, best_e_next;
    logic [TAG_WIDTH-1:0] best_tag_reg, best_tag_next;

    logic [LEN_W-1:0]     lc_in;
    logic [SEQ_WIDTH:0]   in_mask;
    logic [SQW-1:0]       sq_arr [LAGS_PER_CYCLE];
    logic [ACC_W-1:0]     lag_sum;
    logic                 last_step;
    logic [CMP_W-1:0]     acc_wide;
    logic [E_WIDTH-1:0]   e_sat;
    logic [E_WIDTH-1:0]   best_cmp;
    logic                 handshake;

    assign lc_in   = (i_len > LEN_W'(SEQ_WIDTH)) ? LEN_W'(SEQ_WIDTH) : i_len;
    assign in_mask = ((SEQ_WIDTH + 1)'(1) << lc_in) - (SEQ_WIDTH + 1)'(1);

    // One autocorrelation lane per lag evaluated this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < LAGS_PER_CYCLE; gi++) begin : g_lag
            logic [KW-1:0]         lag;
            logic [KW-1:0]         run;
            logic                  lag_ok;
            logic [SEQ_WIDTH-1:0]  run_mask;
            logic [SEQ_WIDTH-1:0]  agree;
            logic [LEN_W-1:0]      a;
            logic signed [CW-1:0]  c;
            logic signed [SQW-1:0] c_ext;

            assign lag      = k_reg + KW'(gi);
            assign lag_ok   = lag < {1'b0, lc_reg};
            assign run      = {1'b0, lc_reg} - lag;
            assign run_mask = (SEQ_WIDTH'(1) << run) - SEQ_WIDTH'(1);
            assign agree    = ~(seq_reg ^ (seq_reg >> lag)) & run_mask;

            always_comb begin
                a = '0;
                for (int j = 0; j < SEQ_WIDTH; j++) begin
                    a = a + LEN_W'(agree[j]);
                end
            end

            // C_k = agreements - disagreements = 2a - run.
            assign c           = CW'({a, 1'b0}) - CW'(run);
            assign c_ext       = SQW'(c);
            assign sq_arr[gi]  = lag_ok ? SQW'(c_ext * c_ext) : '0;
        end
    endgenerate

    always_comb begin
        lag_sum = '0;
        for (int i = 0; i < LAGS_PER_CYCLE; i++) begin
            lag_sum = lag_sum + ACC_W'(sq_arr[i]);
        end
    end

    assign last_step = ({1'b0, k_reg} + (KW + 1)'(LAGS_PER_CYCLE)) >= (KW + 1)'(lc_reg);
    assign acc_wide  = CMP_W'(acc_reg);
    assign e_sat     = (acc_wide > CMP_W'({E_WIDTH{1'b1}})) ? {E_WIDTH{1'b1}}
                                                            : acc_wide[E_WIDTH-1:0];
    assign handshake = valid_reg & i_ready;

    always_comb begin
        state_next   = state_reg;
        seq_next     = seq_reg;
        lc_next      = lc_reg;
        tag_next     = tag_reg;
        k_next       = k_reg;
        acc_next     = acc_reg;
        valid_next   = valid_reg;
        e_next       = e_reg;
        out_tag_next = out_tag_reg;
        case (state_reg)
            IDLE: begin
                if (i_valid) begin
                    state_next = CALC;
                    seq_next   = i_seq & in_mask[SEQ_WIDTH-1:0];
                    lc_next    = lc_in;
                    tag_next   = i_tag;
                    k_next     = KW'(1);
                    acc_next   = '0;
                end
            end
            CALC: begin
                acc_next = acc_reg + lag_sum;
                k_next   = k_reg + KW'(LAGS_PER_CYCLE);
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // First DONE cycle publishes the result; it then holds until taken.
                if (!valid_reg) begin
                    valid_next   = 1'b1;
                    e_next       = e_sat;
                    out_tag_next = tag_reg;
                end else if (i_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        ready_next = (state_next == IDLE);
    end

    // A clear coinciding with a result handshake is applied before the compare.
    always_comb begin
        best_cmp      = i_clr_best ? {E_WIDTH{1'b1}} : best_e_reg;
        best_e_next   = best_cmp;
        best_tag_next = i_clr_best ? '0 : best_tag_reg;
        if (handshake && (e_reg < best_cmp)) begin
            best_e_next   = e_reg;
            best_tag_next = out_tag_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            seq_reg      <= '0;
            lc_reg       <= '0;
            tag_reg      <= '0;
            k_reg        <= '0;
            acc_reg      <= '0;
            ready_reg    <= 1'b1;
            valid_reg    <= 1'b0;
            e_reg        <= '0;
            out_tag_reg  <= '0;
            best_e_reg   <= '1;
            best_tag_reg <= '0;
        end else begin
            state_reg    <= state_next;
            seq_reg      <= seq_next;
            lc_reg       <= lc_next;
            tag_reg      <= tag_next;
            k_reg        <= k_next;
            acc_reg      <= acc_next;
            ready_reg    <= ready_next;
            valid_reg    <= valid_next;
            e_reg        <= e_next;
            out_tag_reg  <= out_tag_next;
            best_e_reg   <= best_e_next;
            best_tag_reg <= best_tag_next;
        end
    end

    assign o_ready    = ready_reg;
    assign o_valid    = valid_reg;
    assign o_e        = e_reg;
    assign o_tag      = out_tag_reg;
    assign o_best_e   = best_e_reg;
    assign o_best_tag = best_tag_reg;

endmodule

// File: tb/tb_calc_e_iter.sv
// Scoreboard bench for calc_e_iter: default build plus an E_WIDTH=12 build fed the same stimulus.
module tb_calc_e_iter;
    localparam int SW    = 30;
    localparam int EW    = 20;
    localparam int TW    = 8;
    localparam int LW    = 5;
    localparam int E_MAX = (1 << EW) - 1;
    localparam int S_MAX = 4095;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] i_seq;
    logic [LW-1:0] i_len;
    logic [TW-1:0] i_tag;
    logic          i_valid;
    logic          i_ready;
    logic          i_clr_best;
    logic          o_ready, o_valid;
    logic [EW-1:0] o_e, o_best_e;
    logic [TW-1:0] o_tag, o_best_tag;
    logic          o_ready_s, o_valid_s;
    logic [11:0]   o_e_s, o_best_e_s;
    logic [TW-1:0] o_tag_s, o_best_tag_s;

    calc_e_iter dut (
        .clk(clk), .rst(rst), .i_seq(i_seq), .i_len(i_len), .i_tag(i_tag),
        .i_valid(i_valid), .o_ready(o_ready), .o_e(o_e), .o_tag(o_tag),
        .o_valid(o_valid), .i_ready(i_ready), .i_clr_best(i_clr_best),
        .o_best_e(o_best_e), .o_best_tag(o_best_tag)
    );

    calc_e_iter #(.E_WIDTH(12)) dut_sat (
        .clk(clk), .rst(rst), .i_seq(i_seq), .i_len(i_len), .i_tag(i_tag),
        .i_valid(i_valid), .o_ready(o_ready_s), .o_e(o_e_s), .o_tag(o_tag_s),
        .o_valid(o_valid_s), .i_ready(i_ready), .i_clr_best(i_clr_best),
        .o_best_e(o_best_e_s), .o_best_tag(o_best_tag_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          e;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t          sb[$];
    int            pass_cnt  = 0;
    int            check_cnt = 0;
    int            best_model;
    logic [TW-1:0] best_tag_model;

    // Energy from the +-1 products directly, saturated to the default result width.
    function automatic int model_e(input logic [SW-1:0] s, input int len);
        int lc, e, c;
        lc = (len > SW) ? SW : len;
        e  = 0;
        for (int k = 1; k < lc; k++) begin
            c = 0;
            for (int j = 0; j + k < lc; j++) c += (s[j] == s[j+k]) ? 1 : -1;
            e += c * c;
        end
        if (e > E_MAX) e = E_MAX;
        return e;
    endfunction

    function automatic int model_lat(input int len);
        int lc;
        lc = (len > SW) ? SW : len;
        if (lc <= 1) return 2;
        return (lc - 1 + 3) / 4 + 1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        best_model     = E_MAX;
        best_tag_model = '0;
        sb.delete();
    endtask

    // Present one beat; pushes expected result at the accepting edge, returns at the next negedge.
    task automatic send(input logic [SW-1:0] s, input int len, input logic [TW-1:0] tag,
                        input int exp_e);
        int guard = 0;
        exp_t ex;
        @(negedge clk);
        while (!o_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        i_seq   = s;
        i_len   = LW'(len);
        i_tag   = tag;
        i_valid = 1'b1;
        @(posedge clk);
        ex.e   = (exp_e < 0) ? model_e(s, len) : exp_e;
        ex.tag = tag;
        sb.push_back(ex);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic do_txn(input logic [SW-1:0] s, input int len, input logic [TW-1:0] tag,
                          input int exp_e, input bit clr);
        int   n = 0;
        int   lat;
        int   exp_s;
        exp_t ex;
        send(s, len, tag, exp_e);
        lat = model_lat(len);
        ex  = sb.pop_front();
        while (!o_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_cnt++;
        if (!o_valid) begin
            $display("FAIL valid_timeout tag=%0d got o_valid=0 want 1 within 100 cycles", tag);
            return;
        end
        pass_cnt++;
        check_cnt++;
        if (n !== lat) $display("FAIL latency tag=%0d got %0d want %0d", tag, n, lat);
        else pass_cnt++;
        check_cnt++;
        if (o_e !== EW'(ex.e)) $display("FAIL energy tag=%0d got %0d want %0d", tag, o_e, ex.e);
        else pass_cnt++;
        check_cnt++;
        if (o_tag !== ex.tag) $display("FAIL tag got %0d want %0d", o_tag, ex.tag);
        else pass_cnt++;
        exp_s = (ex.e > S_MAX) ? S_MAX : ex.e;
        check_cnt++;
        if (o_valid_s !== 1'b1 || o_e_s !== 12'(exp_s) || o_tag_s !== ex.tag)
            $display("FAIL sat_energy tag=%0d got v=%0d e=%0d t=%0d want v=1 e=%0d t=%0d",
                     tag, o_valid_s, o_e_s, o_tag_s, exp_s, ex.tag);
        else pass_cnt++;
        i_clr_best = clr;
        @(posedge clk);
        if (clr) begin
            best_model     = E_MAX;
            best_tag_model = '0;
        end
        if (ex.e < best_model) begin
            best_model     = ex.e;
            best_tag_model = ex.tag;
        end
        @(negedge clk);
        i_clr_best = 1'b0;
        check_cnt++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_ready_s !== 1'b1)
            $display("FAIL post_handshake tag=%0d got v=%0d r=%0d rs=%0d want v=0 r=1 rs=1",
                     tag, o_valid, o_ready, o_ready_s);
        else pass_cnt++;
        $display("txn tag=%0d len=%0d e=%0d exp=%0d lat=%0d", tag, len, o_e, ex.e, n);
    endtask

    task automatic test_reset();
        do_reset();
        check_cnt++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0)
            $display("FAIL reset_handshake got r=%0d v=%0d want r=1 v=0", o_ready, o_valid);
        else pass_cnt++;
        check_cnt++;
        if (o_e !== '0 || o_tag !== '0)
            $display("FAIL reset_result got e=%0d t=%0d want 0 0", o_e, o_tag);
        else pass_cnt++;
        check_cnt++;
        if (o_best_e !== {EW{1'b1}} || o_best_tag !== '0)
            $display("FAIL reset_best got e=%0d t=%0d want %0d 0", o_best_e, o_best_tag, E_MAX);
        else pass_cnt++;
        check_cnt++;
        if (o_best_e_s !== 12'hFFF || o_best_tag_s !== '0)
            $display("FAIL reset_best_sat got e=%0d t=%0d want 4095 0", o_best_e_s, o_best_tag_s);
        else pass_cnt++;
        $display("txn reset");
    endtask

    task automatic test_spec_vectors();
        do_txn(30'b110, 3, 8'h11, 1, 1'b0);
        do_txn(30'h1F35, 13, 8'h22, 6, 1'b0);
        do_txn(30'h000F_FFFF, 20, 8'h33, 2470, 1'b0);
        do_txn(30'h3FFF_FFFF, 30, 8'h44, 8555, 1'b0);
    endtask

    task automatic test_hold_ready();
        int   n = 0;
        exp_t ex;
        i_ready = 1'b0;
        send(30'h1F35, 13, 8'h5A, 6);
        ex = sb.pop_front();
        while (!o_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 10; c++) begin
            i_seq   = SW'($urandom);
            i_len   = 5'd5;
            i_tag   = 8'hFF;
            i_valid = 1'b1;
            check_cnt++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0)
                $display("FAIL hold_flags cyc=%0d got v=%0d r=%0d want v=1 r=0", c, o_valid, o_ready);
            else pass_cnt++;
            check_cnt++;
            if (o_e !== EW'(ex.e) || o_tag !== ex.tag)
                $display("FAIL hold_result cyc=%0d got e=%0d t=%0d want e=%0d t=%0d",
                         c, o_e, o_tag, ex.e, ex.tag);
            else pass_cnt++;
            @(negedge clk);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk);
        if (ex.e < best_model) begin
            best_model     = ex.e;
            best_tag_model = ex.tag;
        end
        @(negedge clk);
        check_cnt++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1)
            $display("FAIL hold_release got v=%0d r=%0d want v=0 r=1", o_valid, o_ready);
        else pass_cnt++;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (o_valid) n++;
        end
        check_cnt++;
        if (n !== 0) $display("FAIL hold_ignored got %0d valid cycles want 0", n);
        else pass_cnt++;
        $display("txn hold tag=%0d e=%0d", ex.tag, ex.e);
    endtask

    task automatic test_best();
        do_reset();
        do_txn(30'h3FFF_FFFF, 30, 8'd1, 8555, 1'b0);
        do_txn(30'h1F35, 13, 8'd2, 6, 1'b0);
        do_txn(30'h1F35, 13, 8'd7, 6, 1'b0);
        check_cnt++;
        if (o_best_e !== EW'(best_model) || o_best_tag !== best_tag_model)
            $display("FAIL best_tie got e=%0d t=%0d want e=%0d t=%0d",
                     o_best_e, o_best_tag, best_model, best_tag_model);
        else pass_cnt++;
        do_txn(30'b110, 3, 8'd4, 1, 1'b0);
        check_cnt++;
        if (o_best_e !== EW'(best_model) || o_best_tag !== best_tag_model)
            $display("FAIL best_min got e=%0d t=%0d want e=%0d t=%0d",
                     o_best_e, o_best_tag, best_model, best_tag_model);
        else pass_cnt++;
        do_txn(30'h000F_FFFF, 20, 8'd9, 2470, 1'b1);
        check_cnt++;
        if (o_best_e !== EW'(best_model) || o_best_tag !== best_tag_model)
            $display("FAIL best_clr_hs got e=%0d t=%0d want e=%0d t=%0d",
                     o_best_e, o_best_tag, best_model, best_tag_model);
        else pass_cnt++;
        i_clr_best = 1'b1;
        @(negedge clk);
        i_clr_best = 1'b0;
        check_cnt++;
        if (o_best_e !== {EW{1'b1}})
            $display("FAIL best_clr got %0d want %0d", o_best_e, E_MAX);
        else pass_cnt++;
        best_model     = E_MAX;
        best_tag_model = '0;
    endtask

    task automatic test_reset_mid_calc();
        int n = 0;
        send(30'h3FFF_FFFF, 30, 8'h3C, 8555);
        void'(sb.pop_front());
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_cnt++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_e !== '0 || o_tag !== '0 ||
            o_best_e !== {EW{1'b1}} || o_best_tag !== '0)
            $display("FAIL midcalc_reset got v=%0d r=%0d e=%0d t=%0d be=%0d bt=%0d want 0 1 0 0 %0d 0",
                     o_valid, o_ready, o_e, o_tag, o_best_e, o_best_tag, E_MAX);
        else pass_cnt++;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_valid) n++;
        end
        check_cnt++;
        if (n !== 0) $display("FAIL midcalc_abort got %0d valid cycles want 0", n);
        else pass_cnt++;
        best_model     = E_MAX;
        best_tag_model = '0;
        $display("txn reset_mid_calc");
    endtask

    task automatic test_back_to_back();
        int lens[4] = '{0, 1, 2, 31};
        for (int i = 0; i < 4; i++) do_txn(SW'($urandom), lens[i], 8'(8'h80 + i), -1, 1'b0);
        for (int i = 0; i < 8; i++)
            do_txn(SW'($urandom), $urandom_range(2, 30), 8'(8'hA0 + i), -1, 1'b0);
        check_cnt++;
        if (o_best_e !== EW'(best_model) || o_best_tag !== best_tag_model)
            $display("FAIL best_random got e=%0d t=%0d want e=%0d t=%0d",
                     o_best_e, o_best_tag, best_model, best_tag_model);
        else pass_cnt++;
    endtask

    initial begin
        rst        = 1'b1;
        i_seq      = '0;
        i_len      = '0;
        i_tag      = '0;
        i_valid    = 1'b0;
        i_ready    = 1'b1;
        i_clr_best = 1'b0;
        test_reset();
        test_spec_vectors();
        test_hold_ready();
        test_best();
        test_reset_mid_calc();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got no finish want finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
